// File: rtl/qec_pkg.sv
// qec_pkg: shared encodings, widths and FSM states for the QEC round scheduler
package qec_pkg;
  localparam int SYN_W  = 4;
  localparam int CORR_W = 5;
  typedef enum logic [1:0] {AXIS_NONE = 2'b00, AXIS_X = 2'b01, AXIS_Y = 2'b10, AXIS_Z = 2'b11} axis_e;
  typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_MISMATCH = 2'b01, ERR_TIMEOUT = 2'b10, ERR_LUTFAULT = 2'b11} err_e;
  typedef enum logic [2:0] {S_IDLE, S_MEAS1, S_MEAS2, S_SETTLE, S_COLLECT, S_PRESENT} state_e;
  function automatic logic exactly_one(input logic [2:0] v);
    return v == 3'b001 || v == 3'b010 || v == 3'b100;
  endfunction
endpackage

// File: rtl/qec_axis_collector.sv
// qec_axis_collector: seen-mask and per-axis correction registers fed by the LUT
module qec_axis_collector
  import qec_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_clear,
  input  logic              i_capture,
  input  logic [1:0]        i_axis,
  input  logic [CORR_W-1:0] i_corr,
  output logic [CORR_W-1:0] o_cx,
  output logic [CORR_W-1:0] o_cy,
  output logic [CORR_W-1:0] o_cz,
  output logic              o_done
);
  logic [2:0]        r_seen;
  logic [CORR_W-1:0] r_cx, r_cy, r_cz;
  logic [2:0]        w_sel, w_new;
  assign w_sel = {i_axis == AXIS_Z, i_axis == AXIS_Y, i_axis == AXIS_X};
  // only the first report per axis counts; repeats and AXIS_NONE are dropped
  assign w_new = i_capture ? (w_sel & ~r_seen) : 3'b000;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seen <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_cz   <= '0;
    end else if (i_clear) begin
      r_seen <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_cz   <= '0;
    end else begin
      r_seen <= r_seen | w_new;
      if (w_new[0]) r_cx <= i_corr;
      if (w_new[1]) r_cy <= i_corr;
      if (w_new[2]) r_cz <= i_corr;
    end
  end
  assign o_cx   = r_cx;
  assign o_cy   = r_cy;
  assign o_cz   = r_cz;
  assign o_done = &r_seen;
endmodule

// File: rtl/qec_round_scheduler.sv
// qec_round_scheduler: runs one measure/compare/LUT/present round of the 5-qubit code decoder
module qec_round_scheduler
  import qec_pkg::*;
#(
  parameter int SETTLE      = 2,
  parameter int ACK_TIMEOUT = 15,
  parameter int RCNT_W      = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              meas_req,
  input  logic              meas_ack,
  input  logic [SYN_W-1:0]  meas_syn,
  output logic [SYN_W-1:0]  lut_ancilla,
  input  logic [1:0]        lut_axis,
  input  logic [CORR_W-1:0] lut_corr,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [SYN_W-1:0]  frame_syn,
  output logic [CORR_W-1:0] frame_cx,
  output logic [CORR_W-1:0] frame_cy,
  output logic [CORR_W-1:0] frame_cz,
  output logic [1:0]        frame_err,
  output logic [RCNT_W-1:0] round_cnt,
  output logic              busy
);
  state_e            r_state;
  logic              r_meas_req, r_valid;
  logic [3:0]        r_tcnt, r_scnt;
  logic [SYN_W-1:0]  r_s1, r_syn, r_lut;
  logic [1:0]        r_err;
  logic [RCNT_W-1:0] r_rcnt;
  logic              w_clear, w_done, w_tout;
  logic [2:0]        w_nz;
  assign w_clear = (r_state == S_IDLE && start) || (r_state == S_PRESENT && frame_ready);
  assign w_tout  = r_tcnt == 4'(ACK_TIMEOUT);
  assign w_nz    = {|frame_cz, |frame_cy, |frame_cx};
  qec_axis_collector u_coll (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_clear  (w_clear),
    .i_capture(r_state == S_COLLECT),
    .i_axis   (lut_axis),
    .i_corr   (lut_corr),
    .o_cx     (frame_cx),
    .o_cy     (frame_cy),
    .o_cz     (frame_cz),
    .o_done   (w_done)
  );
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_meas_req <= 1'b0;
      r_valid    <= 1'b0;
      r_tcnt     <= '0;
      r_scnt     <= '0;
      r_s1       <= '0;
      r_syn      <= '0;
      r_lut      <= '0;
      r_err      <= ERR_OK;
      r_rcnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state    <= S_MEAS1;
          r_meas_req <= 1'b1;
          r_tcnt     <= '0;
        end
        S_MEAS1: if (meas_ack) begin
          r_s1       <= meas_syn;
          r_meas_req <= 1'b0;
          r_tcnt     <= '0;
          r_state    <= S_MEAS2;
        end else if (w_tout) begin
          r_meas_req <= 1'b0;
          r_syn      <= '0;
          r_err      <= ERR_TIMEOUT;
          r_valid    <= 1'b1;
          r_state    <= S_PRESENT;
        end else r_tcnt <= r_tcnt + 4'd1;
        // the first MEAS2 cycle is the mandatory one-cycle request gap
        S_MEAS2: if (!r_meas_req) r_meas_req <= 1'b1;
        else if (meas_ack) begin
          r_meas_req <= 1'b0;
          r_syn      <= meas_syn;
          if (meas_syn != r_s1 || meas_syn == '0) begin
            r_err   <= meas_syn != r_s1 ? ERR_MISMATCH : ERR_OK;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else begin
            r_lut   <= meas_syn;
            r_scnt  <= '0;
            r_state <= S_SETTLE;
          end
        end else if (w_tout) begin
          r_meas_req <= 1'b0;
          r_syn      <= '0;
          r_err      <= ERR_TIMEOUT;
          r_valid    <= 1'b1;
          r_state    <= S_PRESENT;
        end else r_tcnt <= r_tcnt + 4'd1;
        S_SETTLE: if (r_scnt == 4'(SETTLE - 1)) r_state <= S_COLLECT;
        else r_scnt <= r_scnt + 4'd1;
        S_COLLECT: if (w_done) begin
          r_err   <= exactly_one(w_nz) ? ERR_OK : ERR_LUTFAULT;
          r_valid <= 1'b1;
          r_state <= S_PRESENT;
        end
        S_PRESENT: if (frame_ready) begin
          r_valid <= 1'b0;
          r_rcnt  <= r_rcnt + 1'b1;
          r_lut   <= '0;
          r_syn   <= '0;
          r_err   <= ERR_OK;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign meas_req    = r_meas_req;
  assign lut_ancilla = r_lut;
  assign frame_valid = r_valid;
  assign frame_syn   = r_syn;
  assign frame_err   = r_err;
  assign round_cnt   = r_rcnt;
  assign busy        = r_state != S_IDLE;
endmodule

// File: tb/tb_qec_round_scheduler.sv
// tb_qec_round_scheduler: directed checks of the round scheduler against a 2-stage rotating LUT model
module tb_qec_round_scheduler;
  logic       CLK = 1'b0, RST_N = 1'b0, start = 1'b0, meas_ack = 1'b0, frame_ready = 1'b0;
  logic [3:0] meas_syn = 4'd0;
  logic       meas_req, frame_valid, busy;
  logic [3:0] lut_ancilla, frame_syn;
  logic [1:0] lut_axis, frame_err;
  logic [4:0] lut_corr, frame_cx, frame_cy, frame_cz;
  logic [7:0] round_cnt;
  logic [3:0] r_a1;
  logic [1:0] r_rot;
  logic [6:0] w_ent;
  int         nvec = 0, nerr = 0;
  logic [7:0] exp_cnt = 8'd0;

  qec_round_scheduler dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .meas_req(meas_req), .meas_ack(meas_ack),
    .meas_syn(meas_syn), .lut_ancilla(lut_ancilla), .lut_axis(lut_axis), .lut_corr(lut_corr),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_syn(frame_syn),
    .frame_cx(frame_cx), .frame_cy(frame_cy), .frame_cz(frame_cz), .frame_err(frame_err),
    .round_cnt(round_cnt), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // syndrome -> {axis, one-hot qubit}; 0011 models a faulty entry with no correction
  function automatic logic [6:0] lut_entry(input logic [3:0] s);
    case (s)
      4'b0001: return {2'b01, 5'b10000};
      4'b1000: return {2'b01, 5'b01000};
      4'b1111: return {2'b10, 5'b00010};
      4'b0100: return {2'b11, 5'b00001};
      4'b0011: return 7'd0;
      default: return {2'b01, 5'b00001};
    endcase
  endfunction
  assign w_ent = lut_entry(r_a1);

  // LUT: ancilla registered, then one axis report per cycle rotating X, Y, Z
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_a1 <= 4'd0; r_rot <= 2'd1; lut_axis <= 2'd0; lut_corr <= 5'd0;
    end else begin
      r_a1     <= lut_ancilla;
      lut_axis <= r_a1 == 4'd0 ? 2'd0 : r_rot;
      lut_corr <= (r_a1 != 4'd0 && w_ent[6:5] == r_rot) ? w_ent[4:0] : 5'd0;
      r_rot    <= (r_a1 == 4'd0 || r_rot == 2'd3) ? 2'd1 : r_rot + 2'd1;
    end

  // pulses start, acks each request with a then b, returns edges from start to frame_valid (-1 if none)
  task automatic run_round(input logic [3:0] a, b, input bit ack, input int limit, output int cyc, output bit nz);
    int n = 0;
    cyc = -1; nz = 0;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      if (frame_valid) begin cyc = i - 1; break; end
      if (lut_ancilla != 4'd0) nz = 1;
      meas_ack = ack && meas_req;
      meas_syn = n == 0 ? a : b;
      if (meas_ack) n++;
      @(negedge CLK);
    end
    meas_ack = 1'b0;
  endtask

  task automatic accept();
    @(negedge CLK) frame_ready = 1'b1;
    @(negedge CLK) frame_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if ({meas_req, frame_valid, busy, lut_ancilla, frame_syn, frame_cx, frame_cy, frame_cz, frame_err, round_cnt} !== 36'd0) begin
      nerr++; $display("FAIL reset_outputs: got req=%b v=%b busy=%b anc=%h syn=%h cnt=%h want all 0", meas_req, frame_valid, busy, lut_ancilla, frame_syn, round_cnt);
    end
    @(negedge CLK) RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int c; bit nz;
    run_round(4'b0001, 4'b0001, 1, 14, c, nz);
    nvec++; if (c < 0 || c > 10) begin nerr++; $display("FAIL basic_latency: got %0d want 0..10", c); end
    nvec++; if ({frame_syn, frame_cx, frame_cy, frame_cz, frame_err} !== {4'b0001, 5'b10000, 5'd0, 5'd0, 2'b00}) begin
      nerr++; $display("FAIL basic_frame: got syn=%b cx=%b cy=%b cz=%b err=%b want 0001 10000 0 0 00", frame_syn, frame_cx, frame_cy, frame_cz, frame_err);
    end
    accept();
    nvec++; if ({frame_valid, busy, lut_ancilla, round_cnt} !== {1'b0, 1'b0, 4'd0, exp_cnt}) begin
      nerr++; $display("FAIL basic_accept: got v=%b busy=%b anc=%h cnt=%0d want 0 0 0 %0d", frame_valid, busy, lut_ancilla, round_cnt, exp_cnt);
    end
  endtask

  task automatic test_axes();
    int c; bit nz;
    run_round(4'b1111, 4'b1111, 1, 14, c, nz);
    nvec++; if ({frame_cx, frame_cy, frame_cz, frame_err} !== {5'd0, 5'b00010, 5'd0, 2'b00}) begin
      nerr++; $display("FAIL axis_y: got cx=%b cy=%b cz=%b err=%b want 0 00010 0 00", frame_cx, frame_cy, frame_cz, frame_err);
    end
    accept();
    nvec++; if (round_cnt !== exp_cnt) begin nerr++; $display("FAIL cnt_y: got %0d want %0d", round_cnt, exp_cnt); end
    run_round(4'b0100, 4'b0100, 1, 14, c, nz);
    nvec++; if ({frame_cx, frame_cy, frame_cz, frame_err} !== {5'd0, 5'd0, 5'b00001, 2'b00}) begin
      nerr++; $display("FAIL axis_z: got cx=%b cy=%b cz=%b err=%b want 0 0 00001 00", frame_cx, frame_cy, frame_cz, frame_err);
    end
    accept();
    nvec++; if (round_cnt !== exp_cnt) begin nerr++; $display("FAIL cnt_z: got %0d want %0d", round_cnt, exp_cnt); end
  endtask

  task automatic test_mismatch();
    int c; bit nz;
    run_round(4'b0110, 4'b0111, 1, 14, c, nz);
    nvec++; if ({frame_syn, frame_cx, frame_cy, frame_cz, frame_err} !== {4'b0111, 15'd0, 2'b01}) begin
      nerr++; $display("FAIL mismatch_frame: got syn=%b cx=%b cy=%b cz=%b err=%b want 0111 0 0 0 01", frame_syn, frame_cx, frame_cy, frame_cz, frame_err);
    end
    nvec++; if ({nz, lut_ancilla} !== 5'd0) begin nerr++; $display("FAIL mismatch_lut: got driven=%b anc=%h want 0 0", nz, lut_ancilla); end
    accept();
  endtask

  task automatic test_zero();
    int c; bit nz;
    run_round(4'b0000, 4'b0000, 1, 14, c, nz);
    nvec++; if ({c >= 0, frame_syn, frame_cx, frame_cy, frame_cz, frame_err, nz} !== {1'b1, 22'd0}) begin
      nerr++; $display("FAIL zero_frame: got cyc=%0d syn=%b err=%b driven=%b want valid 0 00 0", c, frame_syn, frame_err, nz);
    end
    @(negedge CLK) begin frame_ready = 1'b1; start = 1'b1; end
    @(negedge CLK) begin frame_ready = 1'b0; start = 1'b0; end
    exp_cnt++;
    nvec++; if ({busy, meas_req, frame_valid, round_cnt} !== {3'b000, exp_cnt}) begin
      nerr++; $display("FAIL start_on_accept: got busy=%b req=%b v=%b cnt=%0d want 0 0 0 %0d", busy, meas_req, frame_valid, round_cnt, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int c; bit nz;
    run_round(4'b0101, 4'b0101, 0, 25, c, nz);
    nvec++; if (c < 15 || c > 16) begin nerr++; $display("FAIL timeout_latency: got %0d want 15..16", c); end
    nvec++; if ({meas_req, frame_syn, frame_cx, frame_cy, frame_cz, frame_err} !== {1'b0, 19'd0, 2'b10}) begin
      nerr++; $display("FAIL timeout_frame: got req=%b syn=%b err=%b want 0 0 10", meas_req, frame_syn, frame_err);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      nvec++; if ({frame_valid, busy, frame_syn, frame_cx, frame_cy, frame_cz, frame_err} !== {2'b11, 19'd0, 2'b10}) begin
        nerr++; $display("FAIL stall_%0d: got v=%b syn=%b err=%b want 1 0 10", i, frame_valid, frame_syn, frame_err);
      end
    end
    accept();
    nvec++; if ({frame_valid, busy, round_cnt} !== {2'b00, exp_cnt}) begin
      nerr++; $display("FAIL timeout_accept: got v=%b busy=%b cnt=%0d want 0 0 %0d", frame_valid, busy, round_cnt, exp_cnt);
    end
  endtask

  task automatic test_lut_fault();
    int c; bit nz;
    run_round(4'b0011, 4'b0011, 1, 14, c, nz);
    nvec++; if ({c >= 0, frame_syn, frame_cx, frame_cy, frame_cz, frame_err} !== {1'b1, 4'b0011, 15'd0, 2'b11}) begin
      nerr++; $display("FAIL lut_fault: got cyc=%0d syn=%b err=%b want valid 0011 11", c, frame_syn, frame_err);
    end
    accept();
  endtask

  task automatic test_async_reset();
    int c; bit nz;
    run_round(4'b0001, 4'b0001, 1, 6, c, nz);
    nvec++; if ({busy, frame_valid, frame_cx} !== {2'b10, 5'b10000}) begin
      nerr++; $display("FAIL collect_midway: got busy=%b v=%b cx=%b want 1 0 10000", busy, frame_valid, frame_cx);
    end
    #2 RST_N = 1'b0;
    #1;
    exp_cnt = 8'd0;
    nvec++;
    if ({meas_req, frame_valid, busy, lut_ancilla, frame_syn, frame_cx, frame_cy, frame_cz, frame_err, round_cnt} !== 36'd0) begin
      nerr++; $display("FAIL async_reset: got busy=%b anc=%h syn=%h cx=%b cnt=%0d want all 0", busy, lut_ancilla, frame_syn, frame_cx, round_cnt);
    end
    @(negedge CLK) RST_N = 1'b1;
    run_round(4'b1000, 4'b1000, 1, 14, c, nz);
    nvec++; if ({frame_syn, frame_cx, frame_cy, frame_cz, frame_err} !== {4'b1000, 5'b01000, 10'd0, 2'b00}) begin
      nerr++; $display("FAIL post_reset_round: got syn=%b cx=%b cy=%b cz=%b err=%b want 1000 01000 0 0 00", frame_syn, frame_cx, frame_cy, frame_cz, frame_err);
    end
    accept();
    nvec++; if (round_cnt !== exp_cnt) begin nerr++; $display("FAIL post_reset_cnt: got %0d want %0d", round_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    int c; bit nz;
    for (int k = 0; k < 300 && exp_cnt != 8'hFF; k++) begin
      run_round(4'b0000, 4'b0000, 1, 10, c, nz);
      accept();
    end
    nvec++; if (round_cnt !== 8'hFF) begin nerr++; $display("FAIL wrap_pre: got %h want ff", round_cnt); end
    run_round(4'b0000, 4'b0000, 1, 10, c, nz);
    accept();
    nvec++; if (round_cnt !== 8'h00) begin nerr++; $display("FAIL wrap: got %h want 00", round_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_axes();
    test_mismatch();
    test_zero();
    test_timeout();
    test_lut_fault();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
